// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trap_pkg
//  Description : Shared cause codes, mstatus bit positions, FSM encoding and
//                except_info field offsets for the trap sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package trap_pkg;

    localparam logic [6:0] c_CAUSE_MISALIGN = 7'd0;
    localparam logic [6:0] c_CAUSE_ILLEGAL  = 7'd2;
    localparam logic [6:0] c_CAUSE_EBREAK   = 7'd3;
    localparam logic [6:0] c_CAUSE_ECALL    = 7'd11;
    localparam int unsigned c_IRQ_CAUSE_BASE = 16;

    localparam int unsigned c_MSTATUS_MIE  = 3;
    localparam int unsigned c_MSTATUS_MPIE = 7;

    localparam int unsigned c_INFO_PC_LSB    = 0;
    localparam int unsigned c_INFO_MST_LSB   = 16;
    localparam int unsigned c_INFO_CAUSE_LSB = 24;
    localparam int unsigned c_INFO_IRQ_BIT   = 31;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_TRAP  = 2'd1;
    localparam state_t c_ST_DRAIN = 2'd2;
    localparam state_t c_ST_RET   = 2'd3;

    // Trap entry view of mstatus: MPIE inherits MIE, MIE is cleared.
    function automatic logic [7:0] trap_mstatus(input logic [7:0] mstatus);
        logic [7:0] v;
        v = mstatus;
        v[c_MSTATUS_MPIE] = mstatus[c_MSTATUS_MIE];
        v[c_MSTATUS_MIE]  = 1'b0;
        return v;
    endfunction

    function automatic logic [31:0] pack_info(input logic is_irq, input logic [6:0] cause,
                                              input logic [7:0] mstatus, input logic [15:0] pc);
        logic [31:0] v;
        v = '0;
        v[c_INFO_PC_LSB +: 16]   = pc;
        v[c_INFO_MST_LSB +: 8]   = trap_mstatus(mstatus);
        v[c_INFO_CAUSE_LSB +: 7] = cause;
        v[c_INFO_IRQ_BIT]        = is_irq;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_irq_sync.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sync
//  Description : Parameterised-width two-flop synchroniser, async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl
//  Description : Prioritises exceptions/interrupts, strobes the CSR file and
//                sequences the mtvec redirect, flush and mret return.
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int NUM_IRQ   = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [31:0]        ex_pc,
    input  logic               exc_misalign,
    input  logic               exc_illegal,
    input  logic               exc_ebreak,
    input  logic               exc_ecall,
    input  logic               mret,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [31:0]        csr_info,
    output logic               stall,
    output logic               except,
    output logic               interrupt,
    output logic [31:0]        except_info,
    output logic               pc_sel_trap,
    output logic               pc_sel_ret,
    output logic               flush
);

    localparam logic [2:0] c_DRAIN_LOAD = 3'(FLUSH_CYC - 1);

    logic [NUM_IRQ-1:0] w_irq_s;
    logic [NUM_IRQ-1:0] w_irq_en;
    logic               w_mie;
    logic               w_exc_hit;
    logic               w_irq_hit;
    logic [6:0]         w_cause;
    logic               w_trap_evt;
    logic               w_ret_evt;
    logic               w_latch;
    logic               w_unused;

    state_t     r_state;
    state_t     w_state_nx;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nx;
    logic       r_except;
    logic       r_interrupt;
    logic       r_pc_sel_ret;
    logic       r_flush;
    logic [31:0] r_info;

    irq_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (
        .clk (clk),
        .rst (rst),
        .d   (irq),
        .q   (w_irq_s)
    );

    assign w_mie    = csr_info[c_MSTATUS_MIE];
    assign w_irq_en = w_irq_s & csr_info[16 +: NUM_IRQ] & {NUM_IRQ{w_mie}};
    assign w_unused = ^{csr_info, ex_pc[31:16]};

    always_comb begin
        w_exc_hit = 1'b0;
        w_irq_hit = 1'b0;
        w_cause   = '0;
        if (ex_valid && exc_misalign) begin
            w_exc_hit = 1'b1;
            w_cause   = c_CAUSE_MISALIGN;
        end else if (ex_valid && exc_illegal) begin
            w_exc_hit = 1'b1;
            w_cause   = c_CAUSE_ILLEGAL;
        end else if (ex_valid && exc_ebreak) begin
            w_exc_hit = 1'b1;
            w_cause   = c_CAUSE_EBREAK;
        end else if (ex_valid && exc_ecall) begin
            w_exc_hit = 1'b1;
            w_cause   = c_CAUSE_ECALL;
        end else begin
            // Descending scan so the lowest enabled index is the last writer.
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (w_irq_en[i]) begin
                    w_irq_hit = 1'b1;
                    w_cause   = 7'(c_IRQ_CAUSE_BASE + i);
                end
            end
        end
    end

    assign w_trap_evt = w_exc_hit | w_irq_hit;
    assign w_ret_evt  = ex_valid & mret;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_latch    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_trap_evt) begin
                    w_state_nx = c_ST_TRAP;
                    w_latch    = 1'b1;
                end else if (w_ret_evt) begin
                    w_state_nx = c_ST_RET;
                end
            end
            c_ST_TRAP, c_ST_RET: begin
                w_state_nx = c_ST_DRAIN;
                w_cnt_nx   = c_DRAIN_LOAD;
            end
            c_ST_DRAIN: begin
                if (r_cnt == 3'd0) begin
                    w_state_nx = c_ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 3'd1;
                end
            end
            default: w_state_nx = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_except     <= 1'b0;
            r_interrupt  <= 1'b0;
            r_pc_sel_ret <= 1'b0;
            r_flush      <= 1'b0;
            r_info       <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_except     <= (w_state_nx == c_ST_TRAP);
            r_pc_sel_ret <= (w_state_nx == c_ST_RET);
            r_flush      <= (w_state_nx != c_ST_IDLE);
            if (w_latch) begin
                r_info      <= pack_info(w_irq_hit, w_cause, csr_info[7:0], ex_pc[15:0]);
                r_interrupt <= w_irq_hit;
            end else if (r_state == c_ST_TRAP) begin
                r_interrupt <= 1'b0;
            end
        end
    end

    // Reset gates the combinational stall so every output is low under reset.
    assign stall       = (r_state == c_ST_IDLE) & w_trap_evt & ~rst;
    assign except      = r_except;
    assign interrupt   = r_interrupt;
    assign except_info = r_info;
    assign pc_sel_trap = r_except;
    assign pc_sel_ret  = r_pc_sel_ret;
    assign flush       = r_flush;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_ctrl
//  Description : Scoreboard bench for trap_ctrl with a cycle-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

    localparam int NUM_IRQ   = 4;
    localparam int FLUSH_CYC = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ex_valid = 1'b0;
    logic [31:0]        ex_pc = '0;
    logic               exc_misalign = 1'b0;
    logic               exc_illegal = 1'b0;
    logic               exc_ebreak = 1'b0;
    logic               exc_ecall = 1'b0;
    logic               mret = 1'b0;
    logic [NUM_IRQ-1:0] irq = '0;
    logic [31:0]        csr_info = '0;
    logic               stall, except, interrupt, pc_sel_trap, pc_sel_ret, flush;
    logic [31:0]        except_info;

    trap_ctrl #(.NUM_IRQ(NUM_IRQ), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .exc_misalign(exc_misalign), .exc_illegal(exc_illegal),
        .exc_ebreak(exc_ebreak), .exc_ecall(exc_ecall), .mret(mret),
        .irq(irq), .csr_info(csr_info), .stall(stall), .except(except),
        .interrupt(interrupt), .except_info(except_info),
        .pc_sel_trap(pc_sel_trap), .pc_sel_ret(pc_sel_ret), .flush(flush)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          at;
        logic [31:0] info;
        logic        is_irq;
    } trap_t;

    trap_t              trap_q[$];
    int                 ret_q[$];
    bit                 exp_flush[int];
    bit                 exp_stall[int];
    logic [NUM_IRQ-1:0] irq_drv[int];
    int                 rst_rel = 1 << 30;
    int                 idle_from = 0;
    int                 checks = 0;
    int                 errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Reference: the sequencer is simply busy for 2+FLUSH_CYC cycles after any
    // accepted event; an accepted event is chosen from the priority list.
    task automatic model();
        logic [NUM_IRQ-1:0] s;
        int    cause;
        bit    is_irq;
        logic [7:0] ms;
        s = '0;
        if (cyc - 2 >= rst_rel && irq_drv.exists(cyc - 2)) s = irq_drv[cyc - 2];
        if (cyc < idle_from) return;
        cause  = -1;
        is_irq = 0;
        if (ex_valid) begin
            if (exc_misalign)     cause = 0;
            else if (exc_illegal) cause = 2;
            else if (exc_ebreak)  cause = 3;
            else if (exc_ecall)   cause = 11;
        end
        if (cause < 0 && csr_info[3]) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (s[i] && csr_info[16 + i]) begin
                    cause  = 16 + i;
                    is_irq = 1;
                    break;
                end
            end
        end
        if (cause >= 0) begin
            trap_t t;
            ms = {csr_info[3], csr_info[6:4], 1'b0, csr_info[2:0]};
            t.at     = cyc + 1;
            t.is_irq = is_irq;
            t.info   = {is_irq, 7'(cause), ms, ex_pc[15:0]};
            trap_q.push_back(t);
            exp_stall[cyc] = 1;
        end else if (ex_valid && mret) begin
            ret_q.push_back(cyc + 1);
        end else begin
            return;
        end
        for (int k = 1; k <= 1 + FLUSH_CYC; k++) exp_flush[cyc + k] = 1;
        idle_from = cyc + 2 + FLUSH_CYC;
    endtask

    task automatic apply(input logic v, input logic [31:0] pc, input logic [3:0] exc,
                         input logic m, input logic [NUM_IRQ-1:0] lines, input logic [31:0] csr);
        @(posedge clk);
        #2;
        ex_valid = v;
        ex_pc    = pc;
        {exc_misalign, exc_illegal, exc_ebreak, exc_ecall} = exc;
        mret     = m;
        irq      = lines;
        csr_info = csr;
        irq_drv[cyc] = lines;
        model();
    endtask

    task automatic idle(input int n, input logic [31:0] csr);
        for (int i = 0; i < n; i++) apply(1'b0, 32'h0, 4'b0, 1'b0, '0, csr);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2;
        rst = 1'b0;
        rst_rel = cyc;
        ex_valid = 1'b0;
        {exc_misalign, exc_illegal, exc_ebreak, exc_ecall} = 4'b0;
        mret = 1'b0;
        irq  = '0;
        irq_drv[cyc] = '0;
        model();
    endtask

    always @(negedge clk) begin
        trap_t t;
        if (rst) begin
            chk("reset_ctrl", {26'd0, stall, except, interrupt, pc_sel_trap, pc_sel_ret, flush}, 32'd0);
            chk("reset_info", except_info, 32'd0);
        end else begin
            chk("stall", stall, exp_stall.exists(cyc));
            chk("flush", flush, exp_flush.exists(cyc));
            if (except) begin
                if (trap_q.size() == 0) begin
                    chk("spurious_except", except, 0);
                end else begin
                    t = trap_q.pop_front();
                    chk("except_cycle", cyc, t.at);
                    chk("except_info", except_info, t.info);
                    chk("interrupt", interrupt, t.is_irq);
                    chk("pc_sel_trap", pc_sel_trap, 1);
                end
            end else begin
                chk("interrupt_low", interrupt, 0);
                chk("pc_sel_trap_low", pc_sel_trap, 0);
                if (trap_q.size() > 0 && trap_q[0].at <= cyc) begin
                    chk("missed_except", except, 1);
                    void'(trap_q.pop_front());
                end
            end
            if (pc_sel_ret) begin
                if (ret_q.size() == 0) begin
                    chk("spurious_ret", pc_sel_ret, 0);
                end else begin
                    chk("ret_cycle", cyc, ret_q.pop_front());
                end
            end else if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
                chk("missed_ret", pc_sel_ret, 1);
                void'(ret_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM_IRQ-1:0] lines;
        logic [31:0]        csr;
        logic [3:0]         exc;

        repeat (3) @(posedge clk);
        release_rst();
        idle(2, 32'h0);

        // ECALL with MIE set
        apply(1'b1, 32'h00001234, 4'b0001, 1'b0, '0, 32'h00000008);
        idle(6, 32'h00000008);

        // illegal and ebreak together: illegal wins
        apply(1'b1, 32'h00000040, 4'b0110, 1'b0, '0, 32'h0);
        idle(6, 32'h0);

        // irq[2] enabled, then the same with MIE clear
        for (int i = 0; i < 4; i++) apply(1'b0, 32'h00000500, 4'b0, 1'b0, 4'b0100, 32'h00040008);
        idle(8, 32'h00040008);
        for (int i = 0; i < 4; i++) apply(1'b0, 32'h00000500, 4'b0, 1'b0, 4'b0100, 32'h00040000);
        idle(8, 32'h00040000);

        // exception and irq in the same cycle; irq stays high
        apply(1'b0, 32'h600, 4'b0, 1'b0, 4'b0100, 32'h00040008);
        apply(1'b0, 32'h600, 4'b0, 1'b0, 4'b0100, 32'h00040008);
        apply(1'b1, 32'h604, 4'b0001, 1'b0, 4'b0100, 32'h00040008);
        for (int i = 0; i < 4; i++) apply(1'b0, 32'h608, 4'b0, 1'b0, 4'b0100, 32'h00040008);
        idle(10, 32'h00040008);

        // exception beats mret; mret alone, and mret without ex_valid
        apply(1'b1, 32'h700, 4'b1000, 1'b1, '0, 32'h0);
        idle(6, 32'h0);
        apply(1'b1, 32'h704, 4'b0, 1'b1, '0, 32'h0);
        idle(6, 32'h0);
        apply(1'b0, 32'h708, 4'b0, 1'b1, '0, 32'h0);
        idle(3, 32'h0);

        // reset in the middle of the drain, then a fresh trap
        apply(1'b1, 32'h800, 4'b0100, 1'b0, '0, 32'h0);
        idle(1, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ctrl", {26'd0, stall, except, interrupt, pc_sel_trap, pc_sel_ret, flush}, 32'd0);
        chk("async_rst_info", except_info, 32'd0);
        trap_q.delete();
        ret_q.delete();
        exp_flush.delete();
        exp_stall.delete();
        idle_from = 0;
        release_rst();
        apply(1'b1, 32'h900, 4'b0100, 1'b0, '0, 32'h0);
        idle(6, 32'h0);

        // randomized traffic
        lines = '0;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 15) == 0) lines = NUM_IRQ'($urandom);
            csr = $urandom;
            if ($urandom_range(0, 3) != 0) csr[3] = 1'b1;
            exc = '0;
            for (int b = 0; b < 4; b++) exc[b] = ($urandom_range(0, 11) == 0);
            apply($urandom_range(0, 4) != 0, $urandom, exc, $urandom_range(0, 9) == 0, lines, csr);
        end
        idle(12, 32'h0);

        chk("trap_queue_drained", trap_q.size(), 0);
        chk("ret_queue_drained", ret_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer on the initiating side of the CSR exception interface. It collects synchronous exceptions from EX and external interrupt lines, and prioritises them against the `mstatus`/`mip` state returned on `csr_info`. It then drives a one-cycle `except`/`interrupt` strobe with packed `except_info` into the CSR register file, and sequences the PC redirect to `mtvec`, the pipeline flush and the `mret` return.

## Interface
Parameters:
- `NUM_IRQ`, default 4: external interrupt lines; legal range 1..16.
- `FLUSH_CYC`, default 2: extra flush cycles after the redirect cycle; legal range 1..7.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ex_valid`  in  1  EX holds a real instruction, not a bubble.
- `ex_pc`  in  32  PC of the EX instruction.
- `exc_misalign`  in  1  misaligned fetch or branch target.
- `exc_illegal`  in  1  illegal instruction.
- `exc_ebreak`  in  1  EBREAK.
- `exc_ecall`  in  1  ECALL.
- `mret`  in  1  MRET in EX, qualified by `ex_valid`.
- `irq`  in  NUM_IRQ  asynchronous level interrupt lines.
- `csr_info`  in  32  `{mip[15:0], mstatus[15:0]}` from the CSR file.
- `stall`  out  1  hold IF/ID/EX this cycle; combinational.
- `except`  out  1  trap strobe to the CSR file; registered.
- `interrupt`  out  1  the current trap is an interrupt; registered.
- `except_info`  out  32  `{is_irq, cause[6:0], new_mstatus[7:0], pc[15:0]}`; registered.
- `pc_sel_trap`  out  1  PC mux selects CSR `data_out` (`mtvec`); asserted only while `except`=1.
- `pc_sel_ret`  out  1  PC mux selects CSR `data_out` at the `mepc` alias (`0x002`).
- `flush`  out  1  kill IF/ID/EX contents.

## Operation
- **IRQ input:** each `irq` bit passes through a 2-flop synchroniser to give `irq_s`.
- **Enable:**
  - `mie` = `csr_info[3]`.
  - Line i is enabled when `irq_s[i]` & `csr_info[16+i]` & `mie`.
- **Priority, highest first** (synchronous exceptions require `ex_valid`=1):
  - misalign, cause 0
  - illegal, cause 2
  - ebreak, cause 3
  - ecall, cause 11
  - then the lowest-index enabled irq, cause 16+i
  - then `mret`
- **except_info packing:**
  - [15:0] = `ex_pc[15:0]`.
  - [23:16] = `{mstatus[3], mstatus[6:4], 1'b0, mstatus[2:0]}`: MPIE takes the old MIE and MIE is cleared.
  - [30:24] = cause.
  - [31] = 1 for an interrupt, 0 otherwise.
- **FSM states:** IDLE, TRAP, DRAIN, RET.
  - **IDLE:**
    - A qualifying trap event sets `stall`=1 combinationally and latches `except_info`/`interrupt`; next state is TRAP.
    - `mret` alone: next state is RET.
    - Otherwise stay in IDLE.
  - **TRAP** (exactly one cycle): `except`=1, `pc_sel_trap`=1, `flush`=1. The CSR file captures `except_info` and the fetch PC loads `mtvec` at the closing edge. Next state is DRAIN with the counter loaded to `FLUSH_CYC`-1.
  - **DRAIN:** `flush`=1 while the counter decrements. At 0, next state is IDLE.
  - **RET** (one cycle): `pc_sel_ret`=1, `flush`=1. Next state is DRAIN.
- **Ignored inputs:** in TRAP, DRAIN and RET, all exception, interrupt and `mret` inputs are ignored. Interrupts are levels, so they are re-evaluated in IDLE.
- **Simultaneous events:**
  - Exception together with irq: the exception wins; irq is re-evaluated after drain.
  - Exception together with `mret`: the exception wins.
  - `ex_valid`=0: the exc/`mret` inputs are ignored, but irq can still trap, using the current `ex_pc`.

## Timing
- **Reset** (async, immediate): state IDLE, counter 0, synchroniser flops 0, `except_info`=0. Every output is 0.
- **Reset mid-trap:** returns to IDLE with all outputs 0 asynchronously. The CSR file sees no strobe.
- **Exception latency:** flag in cycle N, `stall` in cycle N, `except` in N+1, `flush` N+1..N+1+`FLUSH_CYC`, IDLE in N+2+`FLUSH_CYC`.
- **Interrupt latency:** an `irq` rising edge before edge E reaches `irq_s` after edge E+1. `except` follows one cycle later.
- **Next trap:** the earliest next trap is the first IDLE cycle; back-to-back traps never overlap.

## Structure
- A shared package `trap_pkg` holds:
  - cause codes 0/2/3/11
  - `IRQ_CAUSE_BASE`=16
  - mstatus bit indices MIE=3, MPIE=7
  - the FSM state enum
  - `except_info` field offsets
- Natural sub-module: `irq_sync`, a parameterised-width 2-flop synchroniser with async reset.

## Test plan
- **ECALL:** reset, `mstatus`=0x0008, `ex_pc`=0x00001234, `exc_ecall`=1.
  - `except` 1 cycle later.
  - `except_info`=0x0B801234, `interrupt`=0, `pc_sel_trap`=1.
  - `flush` for 3 cycles total.
- **Illegal + ebreak together:** `ex_pc`=0x40, `mstatus`=0.
  - `except_info`=0x02000040; a single strobe.
- **irq[2] with MIE=1, mip[2]=1:**
  - `except` 3 cycles after assertion.
  - `except_info[31:24]`=0x92, `interrupt`=1.
  - Repeat with MIE=0: no trap ever.
- **Exception + irq same cycle:** the exception traps first. After DRAIN the still-high irq traps second, and `except` pulses are separated by `FLUSH_CYC`+1 cycles.
- **mret, `ex_valid`=1:** `pc_sel_ret`=1 for 1 cycle, `flush` for 1+`FLUSH_CYC` cycles, `except` stays 0.
- **Reset mid-sequence:** assert `rst` mid-DRAIN.
  - Outputs go to 0 immediately.
  - After release, a new `exc_illegal` traps normally with latency 1.
